// File: rtl/bcd_counter_up_if.sv
// Bundle of the control inputs and status outputs of the two-digit BCD up-counter.
// The master drives count requests and presets; the slave is the counter itself.
interface bcd_counter_up_if;
    logic       enable;
    logic       tick;
    logic       clear;
    logic       load;
    logic [7:0] load_value;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
    logic       carry;
    logic       at_max;
    logic       load_err;

    modport master (
        output enable, tick, clear, load, load_value,
        input  bcd_tens, bcd_units, carry, at_max, load_err
    );

    modport slave (
        input  enable, tick, clear, load, load_value,
        output bcd_tens, bcd_units, carry, at_max, load_err
    );
endinterface

// File: rtl/bcd_counter_up.sv
// Two-digit BCD up-counter with a terminal count of MAX_TENS:MAX_UNITS.
// Counts once per rising edge of tick (when enabled), with synchronous clear and
// validated preset. Define BCD_COUNTER_SATURATE_EN to hold at terminal instead of
// wrapping to 00; the default build wraps and pulses carry on the wrap.
module bcd_counter_up #(
    parameter int MAX_TENS  = 5,
    parameter int MAX_UNITS = 9
) (
    input  logic            clock,
    input  logic            reset,
    bcd_counter_up_if.slave bus
);
    localparam logic [3:0] MAX_T    = 4'(MAX_TENS);
    localparam logic [3:0] MAX_U    = 4'(MAX_UNITS);
    localparam logic [7:0] TERMINAL = {MAX_T, MAX_U};

    logic [3:0] tens_reg, tens_next;
    logic [3:0] units_reg, units_next;
    logic       carry_reg, carry_next;
    logic       load_err_reg, load_err_next;
    logic       tick_q_reg;

    logic       step;
    logic       at_terminal;
    logic       load_ok;
    logic [3:0] inc_tens;
    logic [3:0] inc_units;

    // Edge-qualified count request, terminal detect, preset validation and the
    // decimal increment (units roll into tens in the same cycle).
    always_comb begin
        step        = bus.tick & ~tick_q_reg & bus.enable;
        at_terminal = (tens_reg == MAX_T) && (units_reg == MAX_U);
        load_ok     = (bus.load_value[7:4] <= 4'd9) && (bus.load_value[3:0] <= 4'd9)
                      && (bus.load_value <= TERMINAL);
        if (units_reg == 4'd9) begin
            inc_units = 4'd0;
            inc_tens  = tens_reg + 4'd1;
        end else begin
            inc_units = units_reg + 4'd1;
            inc_tens  = tens_reg;
        end
    end

    // Next-state selection with priority clear > load > step; carry and load_err
    // default low so they only ever last one cycle.
    always_comb begin
        tens_next     = tens_reg;
        units_next    = units_reg;
        carry_next    = 1'b0;
        load_err_next = 1'b0;
        if (bus.clear) begin
            tens_next  = 4'd0;
            units_next = 4'd0;
        end else if (bus.load) begin
            if (load_ok) begin
                tens_next  = bus.load_value[7:4];
                units_next = bus.load_value[3:0];
            end else begin
                load_err_next = 1'b1;
            end
        end else if (step) begin
            if (at_terminal) begin
`ifdef BCD_COUNTER_SATURATE_EN
                // Already holding at terminal: no movement, no further carry.
                tens_next  = tens_reg;
                units_next = units_reg;
`else
                tens_next  = 4'd0;
                units_next = 4'd0;
                carry_next = 1'b1;
`endif
            end else begin
                tens_next  = inc_tens;
                units_next = inc_units;
`ifdef BCD_COUNTER_SATURATE_EN
                // Carry marks the step that arrives at terminal.
                carry_next = ({inc_tens, inc_units} == TERMINAL);
`endif
            end
        end
    end

    // State registers; the tick edge detector samples every cycle so an edge seen
    // during clear/load is consumed rather than deferred.
    always_ff @(posedge clock) begin
        if (reset) begin
            tens_reg     <= 4'd0;
            units_reg    <= 4'd0;
            carry_reg    <= 1'b0;
            load_err_reg <= 1'b0;
            tick_q_reg   <= 1'b0;
        end else begin
            tens_reg     <= tens_next;
            units_reg    <= units_next;
            carry_reg    <= carry_next;
            load_err_reg <= load_err_next;
            tick_q_reg   <= bus.tick;
        end
    end

    assign bus.bcd_tens  = tens_reg;
    assign bus.bcd_units = units_reg;
    assign bus.carry     = carry_reg;
    assign bus.load_err  = load_err_reg;
    assign bus.at_max    = at_terminal;
endmodule

// File: tb/tb_bcd_counter_up.sv
// Directed self-checking bench for bcd_counter_up (default MAX 5:9).
// Compile with BCD_COUNTER_SATURATE_EN defined to exercise the saturating build.
module tb_bcd_counter_up;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   exp_val;
    bit   exp_carry;

    bcd_counter_up_if bus ();

    bcd_counter_up #(.MAX_TENS(5), .MAX_UNITS(9)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare all outputs against a value given as decimal tens*10+units.
    task automatic chk_state(input string tag, input int val, input bit c, input bit m, input bit e);
        chk({tag, ".tens"},     int'(bus.bcd_tens),  val / 10);
        chk({tag, ".units"},    int'(bus.bcd_units), val % 10);
        chk({tag, ".carry"},    int'(bus.carry),     int'(c));
        chk({tag, ".at_max"},   int'(bus.at_max),    int'(m));
        chk({tag, ".load_err"}, int'(bus.load_err),  int'(e));
        $display("%0t %-14s count=%0d%0d carry=%0b at_max=%0b load_err=%0b",
                 $time, tag, bus.bcd_tens, bus.bcd_units, bus.carry, bus.at_max, bus.load_err);
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.load = 1'b1;
        bus.load_value = v;
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.tick = 1'b0;
        bus.clear = 1'b0;
        bus.load = 1'b0;
        bus.load_value = 8'h00;
        cyc();
        cyc();
        reset = 1'b0;
        chk_state("reset", 0, 0, 0, 0);

        // Count sweep: 60 tick pulses with enable high.
        bus.enable = 1'b1;
        exp_val = 0;
        for (int i = 0; i < 60; i++) begin
            bus.tick = 1'b1;
            cyc();
`ifdef BCD_COUNTER_SATURATE_EN
            exp_carry = (exp_val == 58);
            if (exp_val != 59) exp_val = exp_val + 1;
`else
            exp_carry = (exp_val == 59);
            exp_val = (exp_val + 1) % 60;
`endif
            chk_state("sweep", exp_val, exp_carry, exp_val == 59, 0);
            bus.tick = 1'b0;
            cyc();
            chk("sweep.carry_drop", int'(bus.carry), 0);
        end

        // Tick held high for 10 cycles counts exactly once.
        do_reset();
        bus.tick = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_state("hold", 1, 0, 0, 0);
        end
        bus.tick = 1'b0;
        cyc();

        // Enable low: edge ignored; raising enable with tick already high adds nothing.
        bus.enable = 1'b0;
        bus.tick = 1'b1;
        cyc();
        chk_state("disabled", 1, 0, 0, 0);
        bus.enable = 1'b1;
        cyc();
        chk_state("late_enable", 1, 0, 0, 0);
        bus.tick = 1'b0;
        cyc();

        // Load 0x58, two ticks.
        do_load(8'h58);
        chk_state("load58", 58, 0, 0, 0);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        chk_state("tick59", 59, 0, 1, 0);
        cyc();
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
`ifdef BCD_COUNTER_SATURATE_EN
        chk_state("tick_term", 59, 0, 1, 0);
`else
        chk_state("tick_wrap", 0, 1, 0, 0);
`endif
        cyc();
        do_load(8'h23);
        chk_state("load23", 23, 0, 0, 0);

        // Invalid loads: non-BCD nibble, and valid BCD above terminal.
        do_load(8'h6A);
        chk_state("load6A", 23, 0, 0, 1);
        cyc();
        chk_state("err_drop", 23, 0, 0, 0);
        do_load(8'h60);
        chk_state("load60", 23, 0, 0, 1);
        do_load(8'h3C);
        chk_state("load3C", 23, 0, 0, 1);

        // Loading terminal produces no carry.
        do_load(8'h59);
        chk_state("load59", 59, 0, 1, 0);

        // Units roll into tens.
        do_load(8'h19);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        chk_state("roll19", 20, 0, 0, 0);
        cyc();

        // Clear + load 0x30 + tick edge at 42.
        do_load(8'h42);
        chk_state("load42", 42, 0, 0, 0);
        bus.clear = 1'b1;
        bus.load = 1'b1;
        bus.load_value = 8'h30;
        bus.tick = 1'b1;
        cyc();
        bus.clear = 1'b0;
        bus.load = 1'b0;
        chk_state("clr_ld_tick", 0, 0, 0, 0);
        cyc();
        chk_state("edge_consumed", 0, 0, 0, 0);
        bus.tick = 1'b0;
        cyc();

        // Clear wins over an invalid load: no load_err.
        bus.clear = 1'b1;
        bus.load = 1'b1;
        bus.load_value = 8'hFF;
        cyc();
        bus.clear = 1'b0;
        bus.load = 1'b0;
        chk_state("clr_badld", 0, 0, 0, 0);

        // Reset at 37 with a coincident tick edge.
        do_load(8'h37);
        chk_state("load37", 37, 0, 0, 0);
        reset = 1'b1;
        bus.tick = 1'b1;
        cyc();
        reset = 1'b0;
        chk_state("rst_tick", 0, 0, 0, 0);
        bus.tick = 1'b0;
        cyc();
        chk_state("rst_after", 0, 0, 0, 0);

`ifdef BCD_COUNTER_SATURATE_EN
        // Saturating build: three ticks at 59 hold with no carry.
        do_load(8'h59);
        for (int i = 0; i < 3; i++) begin
            bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
            chk_state("sat_hold", 59, 0, 1, 0);
            cyc();
            chk_state("sat_idle", 59, 0, 1, 0);
        end
`else
        // Wrapping build: a step at 59 returns to 00 with carry.
        do_load(8'h59);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        chk_state("wrap59", 0, 1, 0, 0);
        cyc();
        chk_state("wrap_drop", 0, 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
